// File: rtl/hc8_alu.sv
`default_nettype none
//============================================================================
// Module   : hc8_alu
// Purpose  : Parameterised-width integer ALU for the HC8 datapath. Performs
//            add/sub with carry, XOR/OR/AND and pass-through of A or B, and
//            holds the architectural carry and zero flag registers.
// Revision : 1.0 - initial release
//----------------------------------------------------------------------------
// Parameters:
//   WIDTH      data path width of in_A, in_B and out (default 4)
// Ports:
//   clk        in   1      system clock, flags update on rising edge
//   rst_n      in   1      asynchronous active-low reset
//   in_A       in   WIDTH  operand A
//   in_B       in   WIDTH  operand B
//   sel_in     in   3      operation select
//   carry_in   in   1      carry-in (add) / borrow-in (sub)
//   flag_we    in   1      load flag registers at next clk edge
//   out        out  WIDTH  operation result
//   carry_out  out  1      carry (add) / borrow (sub)
//   zero_out   out  1      high when out == 0
//   carry_flag out  1      registered carry flag
//   zero_flag  out  1      registered zero flag
// Build option:
//   ALU_OUT_REG_EN  when defined, out/carry_out/zero_out are registered
//                   (one cycle latency) and flag_we is delayed to match.
//============================================================================
module hc8_alu #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] in_A,
  input  logic [WIDTH-1:0] in_B,
  input  logic [2:0]       sel_in,
  input  logic             carry_in,
  input  logic             flag_we,
  output logic [WIDTH-1:0] out,
  output logic             carry_out,
  output logic             zero_out,
  output logic             carry_flag,
  output logic             zero_flag
);

  localparam logic [2:0] c_OP_PASS_B = 3'b000;
  localparam logic [2:0] c_OP_NOP    = 3'b001;
  localparam logic [2:0] c_OP_ADD    = 3'b010;
  localparam logic [2:0] c_OP_SUB    = 3'b011;
  localparam logic [2:0] c_OP_XOR    = 3'b100;
  localparam logic [2:0] c_OP_OR     = 3'b101;
  localparam logic [2:0] c_OP_AND    = 3'b110;
  localparam logic [2:0] c_OP_PASS_A = 3'b111;

  logic [WIDTH:0]   w_sum;
  logic [WIDTH:0]   w_diff;
  logic [WIDTH-1:0] w_out;
  logic             w_carry;
  logic             w_zero;
  logic             w_flag_en;

  // Both arithmetic paths are evaluated at WIDTH+1 bits. For subtraction the
  // extra bit is the sign of the true difference, which is exactly the borrow:
  // the smallest possible difference is -2^WIDTH, so bit WIDTH is set iff
  // in_A < in_B + carry_in.
  assign w_sum  = {1'b0, in_A} + {1'b0, in_B} + {{WIDTH{1'b0}}, carry_in};
  assign w_diff = {1'b0, in_A} - {1'b0, in_B} - {{WIDTH{1'b0}}, carry_in};

  always_comb begin
    w_out   = '0;
    w_carry = 1'b0;
    case (sel_in)
      c_OP_PASS_B: w_out = in_B;
      c_OP_NOP:    w_out = '0;
      c_OP_ADD:    {w_carry, w_out} = w_sum;
      c_OP_SUB:    {w_carry, w_out} = w_diff;
      c_OP_XOR:    w_out = in_A ^ in_B;
      c_OP_OR:     w_out = in_A | in_B;
      c_OP_AND:    w_out = in_A & in_B;
      c_OP_PASS_A: w_out = in_A;
      default: begin
        w_out   = '0;
        w_carry = 1'b0;
      end
    endcase
  end

  assign w_zero = ~|w_out;

  // The NOP code never touches the flags, even with flag_we asserted.
  assign w_flag_en = flag_we && (sel_in != c_OP_NOP);

`ifdef ALU_OUT_REG_EN

  logic [WIDTH-1:0] r_out;
  logic             r_carry;
  logic             r_zero;
  logic             r_flag_en_d;

  // Registered result path; zero resets high to agree with out = 0.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_out       <= '0;
      r_carry     <= 1'b0;
      r_zero      <= 1'b1;
      r_flag_en_d <= 1'b0;
    end else begin
      r_out       <= w_out;
      r_carry     <= w_carry;
      r_zero      <= w_zero;
      r_flag_en_d <= w_flag_en;
    end
  end

  assign out       = r_out;
  assign carry_out = r_carry;
  assign zero_out  = r_zero;

  // The write enable is delayed one cycle so the flags capture the
  // registered result of the operation that requested the write.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      carry_flag <= 1'b0;
      zero_flag  <= 1'b0;
    end else if (r_flag_en_d) begin
      carry_flag <= r_carry;
      zero_flag  <= r_zero;
    end
  end

`else

  assign out       = w_out;
  assign carry_out = w_carry;
  assign zero_out  = w_zero;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      carry_flag <= 1'b0;
      zero_flag  <= 1'b0;
    end else if (w_flag_en) begin
      carry_flag <= w_carry;
      zero_flag  <= w_zero;
    end
  end

`endif

endmodule
`default_nettype wire

// File: tb/tb_hc8_alu.sv
`default_nettype none
//============================================================================
// Module   : tb_hc8_alu
// Purpose  : Directed self-checking testbench for hc8_alu (WIDTH = 4,
//            combinational output build).
// Revision : 1.0 - initial release
//============================================================================
module tb_hc8_alu;

  localparam int c_WIDTH = 4;

  logic               clk;
  logic               rst_n;
  logic [c_WIDTH-1:0] in_A;
  logic [c_WIDTH-1:0] in_B;
  logic [2:0]         sel_in;
  logic               carry_in;
  logic               flag_we;
  logic [c_WIDTH-1:0] out;
  logic               carry_out;
  logic               zero_out;
  logic               carry_flag;
  logic               zero_flag;

  int check_count;
  int error_count;

  hc8_alu #(.WIDTH(c_WIDTH)) u_dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_A      (in_A),
    .in_B      (in_B),
    .sel_in    (sel_in),
    .carry_in  (carry_in),
    .flag_we   (flag_we),
    .out       (out),
    .carry_out (carry_out),
    .zero_out  (zero_out),
    .carry_flag(carry_flag),
    .zero_flag (zero_flag)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    check_count++;
    if (got !== exp) begin
      error_count++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic apply(input logic [3:0] a, input logic [3:0] b,
                       input logic [2:0] sel, input logic cin);
    in_A     = a;
    in_B     = b;
    sel_in   = sel;
    carry_in = cin;
    #1;
  endtask

  // Checks the three combinational outputs against hand-computed values.
  task automatic check_comb(input string tag, input logic [3:0] exp_out,
                            input logic exp_c, input logic exp_z);
    check({tag, "_out"}, 32'(out), 32'(exp_out));
    check({tag, "_c"},   32'(carry_out), 32'(exp_c));
    check({tag, "_z"},   32'(zero_out), 32'(exp_z));
  endtask

  task automatic check_flags(input string tag, input logic exp_c,
                             input logic exp_z);
    check({tag, "_cf"}, 32'(carry_flag), 32'(exp_c));
    check({tag, "_zf"}, 32'(zero_flag), 32'(exp_z));
  endtask

  initial begin
    check_count = 0;
    error_count = 0;
    rst_n    = 1'b0;
    flag_we  = 1'b0;
    in_A     = '0;
    in_B     = '0;
    sel_in   = 3'b001;
    carry_in = 1'b0;

    #3;
    check_flags("reset", 1'b0, 1'b0);

    @(negedge clk);
    rst_n = 1'b1;

    // Combinational operations (flag_we low throughout)
    apply(4'b0101, 4'b0011, 3'b010, 1'b1); check_comb("add",      4'b1001, 1'b0, 1'b0);
    apply(4'b0110, 4'b0011, 3'b011, 1'b0); check_comb("sub",      4'b0011, 1'b0, 1'b0);
    apply(4'b0010, 4'b0011, 3'b011, 1'b0); check_comb("sub_brw",  4'b1111, 1'b1, 1'b0);
    apply(4'b1100, 4'b1010, 3'b100, 1'b1); check_comb("xor",      4'b0110, 1'b0, 1'b0);
    apply(4'b1100, 4'b1010, 3'b101, 1'b1); check_comb("or",       4'b1110, 1'b0, 1'b0);
    apply(4'b1100, 4'b1010, 3'b110, 1'b1); check_comb("and",      4'b1000, 1'b0, 1'b0);
    apply(4'b1010, 4'b0101, 3'b111, 1'b0); check_comb("pass_a",   4'b1010, 1'b0, 1'b0);
    apply(4'b1010, 4'b0101, 3'b000, 1'b0); check_comb("pass_b",   4'b0101, 1'b0, 1'b0);
    apply(4'b1010, 4'b0101, 3'b001, 1'b1); check_comb("nop",      4'b0000, 1'b0, 1'b1);
    apply(4'b1111, 4'b1111, 3'b010, 1'b1); check_comb("add_max",  4'b1111, 1'b1, 1'b0);
    apply(4'b0000, 4'b0000, 3'b011, 1'b1); check_comb("sub_0m1",  4'b1111, 1'b1, 1'b0);
    apply(4'b0000, 4'b0000, 3'b011, 1'b0); check_comb("sub_0m0",  4'b0000, 1'b0, 1'b1);
    apply(4'b1111, 4'b0001, 3'b010, 1'b0); check_comb("add_wrap", 4'b0000, 1'b1, 1'b1);
    apply(4'b0111, 4'b0111, 3'b100, 1'b0); check_comb("xor_zero", 4'b0000, 1'b0, 1'b1);
    check_flags("no_we", 1'b0, 1'b0);

    // Flag load: 1111 + 0001 + 0 -> carry 1, zero 1
    @(negedge clk);
    apply(4'b1111, 4'b0001, 3'b010, 1'b0);
    flag_we = 1'b1;
    @(posedge clk); #1;
    check_flags("we_add", 1'b1, 1'b1);

    // flag_we low: flags hold while ALU gives carry 0, zero 0
    @(negedge clk);
    flag_we = 1'b0;
    apply(4'b0001, 4'b0001, 3'b010, 1'b0);
    @(posedge clk); #1;
    check_flags("hold_we0", 1'b1, 1'b1);

    // NOP with flag_we high: flags hold
    @(negedge clk);
    flag_we = 1'b1;
    apply(4'b0001, 4'b0001, 3'b001, 1'b0);
    @(posedge clk); #1;
    check_flags("hold_nop", 1'b1, 1'b1);

    // Flags can be cleared by a write: 0001 + 0001 -> carry 0, zero 0
    @(negedge clk);
    apply(4'b0001, 4'b0001, 3'b010, 1'b0);
    @(posedge clk); #1;
    check_flags("we_clr", 1'b0, 1'b0);

    // Carry set, zero clear: 0010 - 0011 -> 1111, borrow
    @(negedge clk);
    apply(4'b0010, 4'b0011, 3'b011, 1'b0);
    @(posedge clk); #1;
    check_flags("we_sub", 1'b1, 1'b0);

    // Set both flags again, then reset mid-cycle without a clock edge
    @(negedge clk);
    apply(4'b1111, 4'b0001, 3'b010, 1'b0);
    @(posedge clk); #1;
    check_flags("we_set", 1'b1, 1'b1);
    flag_we = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    check_flags("async_rst", 1'b0, 1'b0);

    // Release at a negedge; a write on the first following edge is honoured
    @(negedge clk);
    rst_n   = 1'b1;
    flag_we = 1'b1;
    apply(4'b1111, 4'b0001, 3'b010, 1'b0);
    @(posedge clk); #1;
    check_flags("first_edge", 1'b1, 1'b1);
    flag_we = 1'b0;

    $display("Simulation finished: %0d checks, %0d errors", check_count, error_count);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/hc8_alu.md
Name: hc8_alu

Overview:
- Parameterised-width integer ALU for the HC8 datapath: add/sub with carry, XOR/OR/AND, pass-through A or B.
- Combinational result and carry path into the register file / accumulator write-back.
- Holds the architectural carry and zero flag registers, written under control of the sequencer.

Parameters:
- WIDTH, 4, data path width in bits for in_A, in_B and out.

Ports:
- clk  input  1  system clock; flag registers update on the rising edge.
- rst_n  input  1  asynchronous active-low reset.
- in_A  input  WIDTH  operand A.
- in_B  input  WIDTH  operand B.
- sel_in  input  3  operation select.
- carry_in  input  1  carry-in for add; borrow-in for sub; ignored by the other ops.
- flag_we  input  1  when high, latch carry_out/zero_out into the flag registers at the next clk edge.
- out  output  WIDTH  operation result.
- carry_out  output  1  carry (add) or borrow (sub) from the current operation.
- zero_out  output  1  high when out == 0.
- carry_flag  output  1  registered carry flag.
- zero_flag  output  1  registered zero flag.

Behaviour:
Combinational outputs (out, carry_out, zero_out) depend only on in_A, in_B, sel_in and carry_in; no clock latency, no reset dependence.

sel_in decode:
- 000: out = in_B, carry_out = 0.
- 001: out = 0, carry_out = 0 (NOP). flag_we is ignored for this code, so the flags hold.
- 010 ADD: {carry_out, out} = in_A + in_B + carry_in, computed at WIDTH+1 bits.
- 011 SUB: out = (in_A - in_B - carry_in) mod 2^WIDTH. carry_out = 1 when in_A < in_B + carry_in (borrow), else 0.
- 100: out = in_A ^ in_B, carry_out = 0.
- 101: out = in_A | in_B, carry_out = 0.
- 110: out = in_A & in_B, carry_out = 0.
- 111: out = in_A (pass-through), carry_out = 0.

Other combinational rules:
- zero_out = ~|out, for every op.
- No X on outputs for any defined input combination.

Flag registers:
- On rst_n low, carry_flag and zero_flag go to 0 immediately, independent of clk.
- At a rising clk edge with flag_we = 1 and sel_in != 001: carry_flag <= carry_out and zero_flag <= zero_out.
- Otherwise the flags hold.
- Reset deassertion is treated as synchronous to clk by the system; a flag_we on the first edge after release is honoured.

Boundaries:
- ADD 1111+1111+1 gives out = 1111, carry_out = 1.
- SUB 0000-0000-1 gives out = 1111, carry_out = 1.
- SUB 0000-0000-0 gives out = 0000, carry_out = 0, zero_out = 1.

Optional Feature:
ALU_OUT_REG_EN:
- When defined: out, carry_out and zero_out are registered on clk, giving one cycle latency. They reset asynchronously to 0 (zero_out resets to 1, consistent with out = 0). The flag registers then load from the registered values on the edge after flag_we, with flag_we delayed one cycle internally to stay aligned.
- When undefined: fully combinational outputs as described above.

Test Plan:
- ADD: A=0101, B=0011, Cin=1, sel=010 -> out=1001, carry_out=0, zero_out=0.
- SUB: A=0110, B=0011, Cin=0, sel=011 -> out=0011, carry_out=0. Then A=0010, B=0011, Cin=0 -> out=1111, carry_out=1.
- Logic ops with A=1100, B=1010: sel=100 -> 0110; sel=101 -> 1110; sel=110 -> 1000; carry_out=0 for all three.
- Pass-through: A=1010, sel=111 -> out=1010. B=0101, sel=000 -> out=0101. sel=001 -> out=0000, zero_out=1.
- Flags: ADD 1111+0001+0 with flag_we=1, one clk edge -> carry_flag=1, zero_flag=1. With flag_we=0, an ADD giving carry_out=0 -> flags unchanged. With flag_we=1 and sel=001 -> flags unchanged.
- Async reset: assert rst_n=0 mid-cycle with flags set -> carry_flag=0 and zero_flag=0 immediately, with no clk edge required.
